ddr3_frame_writer: RTL



---
 rtl/ddr3_frame_writer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ddr3_frame_writer.sv
// Avalon-MM burst write master: buffers 128-bit pixel words in a FIFO and
// writes one frame of programmed length to DDR3, pulsing done at the end.
// Ports: control_* (base, length, go, busy, done), user_* (FIFO push side),
// master_* (Avalon-MM burst write master).
module ddr3_frame_writer #(
    parameter int DATA_WIDTH          = 128,
    parameter int ADDRESS_WIDTH       = 32,
    parameter int FIFO_DEPTH          = 256,
    parameter int FIFO_DEPTH_LOG2     = 8,
    parameter int MAXIMUM_BURST_COUNT = 16,
    parameter int BURST_COUNT_WIDTH   = 5
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         soft_reset,
    input  logic [ADDRESS_WIDTH-1:0]     control_write_base,
    input  logic [31:0]                  control_write_length,
    input  logic                         control_go,
    output logic                         control_busy,
    output logic                         control_done,
    input  logic                         user_write_buffer,
    input  logic [DATA_WIDTH-1:0]        user_buffer_data,
    output logic                         user_buffer_full,
    output logic [ADDRESS_WIDTH-1:0]     master_address,
    output logic                         master_write,
    output logic [DATA_WIDTH/8-1:0]      master_byteenable,
    output logic [DATA_WIDTH-1:0]        master_writedata,
    output logic [BURST_COUNT_WIDTH-1:0] master_burstcount,
    input  logic                         master_waitrequest
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BS    = $clog2(BYTES);
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, WAIT_DATA, BURST, DONE} state_t;

    state_t                       state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]     addr_q, addr_d;
    logic [BURST_COUNT_WIDTH-1:0] burst_q, burst_d;
    logic [BURST_COUNT_WIDTH-1:0] beats_q, beats_d;
    logic [31:0]                  remain_q, remain_d;
    logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                count_q, count_d;
    logic                         full_q, full_d;
    logic [DATA_WIDTH-1:0]        mem_q [FIFO_DEPTH];

    logic        push_ok;
    logic        pop;
    logic [31:0] words;
    logic [31:0] next_n;
    logic [31:0] count_ext;
    logic        unused_low;

    // Sub-word bits of base and length carry no meaning for a word master.
    assign unused_low = ^{control_write_length[BS-1:0],
                          control_write_base[BS-1:0]};

    assign words     = {{BS{1'b0}}, control_write_length[31:BS]};
    assign count_ext = 32'(count_q);
    assign next_n    = (remain_q < 32'(MAXIMUM_BURST_COUNT)) ?
                       remain_q : 32'(MAXIMUM_BURST_COUNT);

    // Pushes are judged against the true count, not the registered flag.
    assign push_ok = user_write_buffer && (count_q != CW'(FIFO_DEPTH));
    assign pop     = master_write && !master_waitrequest;

    assign master_write      = (state_q == BURST);
    assign control_busy      = (state_q != IDLE);
    assign control_done      = (state_q == DONE);
    assign master_address    = addr_q;
    assign master_burstcount = burst_q;
    assign master_byteenable = '1;
    assign master_writedata  = mem_q[rd_ptr_q];
    assign user_buffer_full  = full_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        burst_d  = burst_q;
        beats_d  = beats_q;
        remain_d = remain_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + FIFO_DEPTH_LOG2'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + FIFO_DEPTH_LOG2'(1);
        if (push_ok && !pop) count_d = count_q + CW'(1);
        if (!push_ok && pop) count_d = count_q - CW'(1);

        unique case (state_q)
            IDLE: begin
                if (control_go) begin
                    addr_d   = {control_write_base[ADDRESS_WIDTH-1:BS],
                                {BS{1'b0}}};
                    remain_d = words;
                    state_d  = (words == 32'd0) ? DONE : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (count_ext >= next_n) begin
                    burst_d = BURST_COUNT_WIDTH'(next_n);
                    beats_d = BURST_COUNT_WIDTH'(next_n);
                    state_d = BURST;
                end
            end
            BURST: begin
                if (pop) begin
                    beats_d  = beats_q - BURST_COUNT_WIDTH'(1);
                    remain_d = remain_q - 32'd1;
                    if (beats_q == BURST_COUNT_WIDTH'(1)) begin
                        addr_d  = addr_q + (ADDRESS_WIDTH'(burst_q) << BS);
                        state_d = (remain_q == 32'd1) ? DONE : WAIT_DATA;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (soft_reset) begin
            state_d  = IDLE;
            addr_d   = '0;
            burst_d  = '0;
            beats_d  = '0;
            remain_d = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        full_d = (count_d == CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            burst_q  <= '0;
            beats_q  <= '0;
            remain_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            burst_q  <= burst_d;
            beats_q  <= beats_d;
            remain_q <= remain_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !soft_reset) mem_q[wr_ptr_q] <= user_buffer_data;
    end

endmodule
